vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised video timing and pixel pipeline for the DE0-Nano VGA/LCD outputs. Generates horizontal/vertical sync, data-enable and pixel coordinates for any mode set by parameters (default 800x480 at 30 MHz). RGB comes either from an external pixel source over a fixed-latency request interface or from a built-in test-pattern generator. Sits between the pixel-clock PLL and the panel pins, and is the timing master for any frame-buffer reader.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP / H_SYNC / H_BP, 40 / 88 / 48, horizontal porch and sync widths in pixels (total 976)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 13 / 3 / 32, vertical porch and sync widths in lines (total 528)
- HS_POL / VS_POL, 1 / 1, active level of HS / VS
- CNT_W, 11, width of counters and coordinates; must hold H_TOTAL-1 and V_TOTAL-1
- COLOR_BITS, 1, bits per colour channel
- CLOCK_PIXEL  in  1  pixel clock; sole clock
- RESET  in  1  synchronous, active-high reset
- MODE  in  2  RGB source: 0 external, 1 colour bars, 2 border+square, 3 checkerboard
- PIX_R / PIX_G / PIX_B  in  COLOR_BITS  external pixel data, valid 1 cycle after PIX_REQ
- PIX_REQ  out  1  external source must return the pixel at PIX_X/PIX_Y next cycle
- PIX_X / PIX_Y  out  CNT_W  requested pixel coordinate
- VGA_RED / VGA_GREEN / VGA_BLUE  out  COLOR_BITS  pixel data
- VGA_HS / VGA_VS  out  1  syncs, polarity per HS_POL/VS_POL
- VGA_DE  out  1  high during active video
- FRAME_START  out  1  one-cycle pulse with output pixel (0,0)

## Operation
- h_cnt counts 0..H_TOTAL-1 every cycle; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt wraps 0 after V_TOTAL-1 on the same cycle h_cnt wraps.
- Active: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE (strict; exactly H_ACTIVE x V_ACTIVE pixels).
- HS active: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. VS active: V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, changing only with h_cnt wrap.
- Stage 1 (registered): PIX_REQ=active, PIX_X=h_cnt, PIX_Y=v_cnt (X/Y hold value also when not active), raw HS/VS/DE/frame flags.
- Stage 2 (registered): RGB from selected source, syncs/DE/FRAME_START delayed one more cycle so all outputs align.
- RGB forced to 0 whenever output DE is low, in every mode.
- MODE sampled only when h_cnt=0 and v_cnt=0; applied for the whole frame. Changes mid-frame take effect next frame.
- Patterns (all-ones/all-zeros per channel): 1 = eight equal bars of width H_ACTIVE/8 (remainder pixels use last bar), order white, yellow, cyan, green, magenta, red, blue, black; 2 = white square x,y in [100,200], green rows 0 and V_ACTIVE-1, red columns 0 and H_ACTIVE-1, else blue; 3 = white when x[5]^y[5], else black.
- External mode: stage 2 registers PIX_R/G/B sampled the cycle after PIX_REQ.

## Timing
- Reset: counters 0, mode latch 0, PIX_REQ 0, PIX_X/PIX_Y 0, RGB 0, DE 0, FRAME_START 0, VGA_HS = !HS_POL, VGA_VS = !VS_POL.
- First cycle after RESET deasserts, h_cnt=v_cnt=0. Counter value n is reflected on stage-1 outputs at cycle n+1 and on VGA_* outputs at cycle n+2.
- Latency h_cnt -> VGA_* is 2 cycles; PIX_REQ -> pixel on VGA_* is 1 cycle.
- RESET asserted mid-line/frame: all state to reset values at the next edge; pipeline flushed; no partial sync pulse held.
- Default frame = 976 x 528 = 515,328 cycles.

## Configuration
- VGA_TIMING_TEST_PATTERN_EN defined: modes 1-3 and mode latch built in as above.
- Undefined: pattern logic and mode latch omitted; MODE port present but ignored; RGB always external (mode 0 behaviour); timing identical.

## Test plan
- Reset release, defaults -> FRAME_START at cycle 2, then every 515,328 cycles; DE high 800 cycles per line, 480 lines per frame.
- Defaults, HS_POL=1 -> VGA_HS high cycles 842..929 of line 0 (88 cycles), low otherwise; VS high for exactly 3 x 976 cycles starting at line 493 output.
- MODE=0, external source returns PIX_R=PIX_X[0] -> VGA_RED alternates 0,1 across line; 0 in blanking.
- MODE switched 0->1 mid-frame -> output unchanged until next FRAME_START, then bar 0 white for x 0..99, bar 7 black for x 700..799.
- MODE=2 -> pixel (150,150) white, (0,50) red, (300,0) green, (300,300) blue.
- RESET pulsed for 1 cycle at h_cnt=500, v_cnt=200 -> next cycle all outputs at reset values; FRAME_START 2 cycles after release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Video timing master: sync/DE/coordinate counters feeding a two-stage pixel pipeline.
// Define VGA_TIMING_TEST_PATTERN_EN to build in test patterns (MODE 1-3) and the per-frame mode latch.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 88,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 13,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 32,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int CNT_W      = 11,
  parameter int COLOR_BITS = 1
) (
  input  logic                  CLOCK_PIXEL,
  input  logic                  RESET,
  input  logic [1:0]            MODE,
  input  logic [COLOR_BITS-1:0] PIX_R,
  input  logic [COLOR_BITS-1:0] PIX_G,
  input  logic [COLOR_BITS-1:0] PIX_B,
  output logic                  PIX_REQ,
  output logic [CNT_W-1:0]      PIX_X,
  output logic [CNT_W-1:0]      PIX_Y,
  output logic [COLOR_BITS-1:0] VGA_RED,
  output logic [COLOR_BITS-1:0] VGA_GREEN,
  output logic [COLOR_BITS-1:0] VGA_BLUE,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic                  VGA_DE,
  output logic                  FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  // Region bounds kept 32 bits wide so a zero back porch cannot overflow CNT_W.
  localparam logic [31:0] H_ACT32 = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT32 = 32'(V_ACTIVE);
  localparam logic [31:0] HS_BEG  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END  = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END  = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [31:0]      h32, v32;
  logic             act_d, hs_d, vs_d, fs_d;

  logic             req_q, hs1_q, vs1_q, fs1_q;
  logic [CNT_W-1:0] x_q, y_q;

  logic [COLOR_BITS-1:0] r_q, g_q, b_q;
  logic [COLOR_BITS-1:0] sel_r, sel_g, sel_b;
  logic                  de_q, hs_q, vs_q, fs_q;

  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    h32   = 32'(h_cnt_q);
    v32   = 32'(v_cnt_q);
    act_d = (h32 < H_ACT32) && (v32 < V_ACT32);
    hs_d  = (h32 >= HS_BEG) && (h32 < HS_END);
    vs_d  = (v32 >= VS_BEG) && (v32 < VS_END);
    fs_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [1:0] mode_q;
  logic [2:0] bar_idx, bar_rgb, pat_rgb;

  // Latched at counter (0,0) so the whole frame, starting with pixel (0,0), uses one source.
  always_ff @(posedge CLOCK_PIXEL) begin
    if (RESET) begin
      mode_q <= 2'd0;
    end else if (fs_d) begin
      mode_q <= MODE;
    end
  end

  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (32'(x_q) >= 32'(i * BAR_W)) bar_idx = 3'(i);
    end
    case (bar_idx)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  always_comb begin
    pat_rgb = 3'b000;
    case (mode_q)
      2'd1: pat_rgb = bar_rgb;
      2'd2: begin
        if ((32'(x_q) >= 32'd100) && (32'(x_q) <= 32'd200) &&
            (32'(y_q) >= 32'd100) && (32'(y_q) <= 32'd200))
          pat_rgb = 3'b111;
        else if ((y_q == '0) || (32'(y_q) == V_ACT32 - 32'd1))
          pat_rgb = 3'b010;
        else if ((x_q == '0) || (32'(x_q) == H_ACT32 - 32'd1))
          pat_rgb = 3'b100;
        else
          pat_rgb = 3'b001;
      end
      2'd3:    pat_rgb = {3{x_q[5] ^ y_q[5]}};
      default: pat_rgb = 3'b000;
    endcase
    if (mode_q == 2'd0) begin
      sel_r = PIX_R;
      sel_g = PIX_G;
      sel_b = PIX_B;
    end else begin
      sel_r = {COLOR_BITS{pat_rgb[2]}};
      sel_g = {COLOR_BITS{pat_rgb[1]}};
      sel_b = {COLOR_BITS{pat_rgb[0]}};
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^MODE;

  always_comb begin
    sel_r = PIX_R;
    sel_g = PIX_G;
    sel_b = PIX_B;
  end
`endif

  // External pixel data must be valid while PIX_REQ/PIX_X/PIX_Y are presented; it is
  // captured at the following edge and appears on VGA_* one cycle after PIX_REQ.
  always_ff @(posedge CLOCK_PIXEL) begin
    if (RESET) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      req_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      fs1_q   <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      de_q    <= 1'b0;
      hs_q    <= !HS_POL;
      vs_q    <= !VS_POL;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      req_q   <= act_d;
      x_q     <= h_cnt_q;
      y_q     <= v_cnt_q;
      hs1_q   <= hs_d;
      vs1_q   <= vs_d;
      fs1_q   <= fs_d;
      r_q     <= req_q ? sel_r : '0;
      g_q     <= req_q ? sel_g : '0;
      b_q     <= req_q ? sel_b : '0;
      de_q    <= req_q;
      hs_q    <= hs1_q ? HS_POL : !HS_POL;
      vs_q    <= vs1_q ? VS_POL : !VS_POL;
      fs_q    <= fs1_q;
    end
  end

  assign PIX_REQ     = req_q;
  assign PIX_X       = x_q;
  assign PIX_Y       = y_q;
  assign VGA_RED     = r_q;
  assign VGA_GREEN   = g_q;
  assign VGA_BLUE    = b_q;
  assign VGA_DE      = de_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign FRAME_START = fs_q;

endmodule
